// File: rtl/mips_run_checker.sv
// Self-check unit for the MIPS pipeline: shadows WB writes, times the run, then checks an expected-register table.
// Optional WB trace FIFO is built when MIPS_RUN_TRACE_EN is defined.
module mips_run_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_CHECKS     = 16,
  parameter int MAX_CYCLES     = 90,
  parameter int TRACE_DEPTH    = 16,
  localparam int IDX_W = $clog2(NUM_CHECKS),
  localparam int CYC_W = $clog2(MAX_CYCLES + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0]            wb_write_register,
  input  logic [DATA_WIDTH-1:0]                wb_write_data,
  input  logic                                 halt,
  input  logic                                 start,
  input  logic                                 exp_wr_en,
  input  logic [IDX_W-1:0]                     exp_idx,
  input  logic                                 exp_valid,
  input  logic [REG_ADDR_WIDTH-1:0]            exp_reg,
  input  logic [DATA_WIDTH-1:0]                exp_value,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 pass,
  output logic                                 timeout,
  output logic [IDX_W:0]                       error_count,
  output logic [IDX_W-1:0]                     first_fail_idx,
  output logic [CYC_W-1:0]                     cycle_count,
  input  logic                                 trace_rd_en,
  output logic [REG_ADDR_WIDTH+DATA_WIDTH-1:0] trace_rd_data,
  output logic                                 trace_empty,
  output logic                                 trace_overflow
);
  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam int ERR_W    = IDX_W + 1;
  localparam logic [CYC_W-1:0] MAX_CYC  = CYC_W'(MAX_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_CHECK = 2'd2, S_DONE = 2'd3} state_t;

  state_t                    r_state;
  logic                      r_busy, r_done, r_pass, r_timeout;
  logic [CYC_W-1:0]          r_cycle_count;
  logic [IDX_W-1:0]          r_idx, r_first_fail;
  logic [ERR_W-1:0]          r_error_count;
  logic [DATA_WIDTH-1:0]     r_shadow    [NUM_REGS];
  logic                      r_exp_valid [NUM_CHECKS];
  logic [REG_ADDR_WIDTH-1:0] r_exp_reg   [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]     r_exp_value [NUM_CHECKS];

  logic             w_cfg, w_start, w_capture, w_exit, w_mismatch;
  logic [CYC_W-1:0] w_cyc_next;
  logic [ERR_W-1:0] w_err_next;

  assign w_cfg      = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start    = start && w_cfg;
  assign w_capture  = (r_state == S_RUN) && wb_reg_write && (wb_write_register != '0);
  assign w_cyc_next = (r_cycle_count == MAX_CYC) ? r_cycle_count : r_cycle_count + CYC_W'(1);
  assign w_exit     = halt || (w_cyc_next == MAX_CYC);
  assign w_mismatch = (r_state == S_CHECK) && r_exp_valid[r_idx] &&
                      (r_shadow[r_exp_reg[r_idx]] != r_exp_value[r_idx]);
  assign w_err_next = r_error_count + ERR_W'(w_mismatch);

  // Run/check sequencer with registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycle_count <= '0;
      r_idx         <= '0;
      r_error_count <= '0;
      r_first_fail  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state       <= S_RUN;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
            r_idx         <= '0;
            r_error_count <= '0;
            r_first_fail  <= '0;
          end
        end
        S_RUN: begin
          r_cycle_count <= w_cyc_next;
          if (w_exit) begin
            r_state   <= S_CHECK;
            r_timeout <= ~halt;
            r_idx     <= '0;
          end
        end
        S_CHECK: begin
          r_idx         <= r_idx + IDX_W'(1);
          r_error_count <= w_err_next;
          if (w_mismatch && (r_error_count == '0)) begin
            r_first_fail <= r_idx;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Shadow register file and expected table; the table survives start but not reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
      for (int j = 0; j < NUM_CHECKS; j++) begin
        r_exp_valid[j] <= 1'b0;
        r_exp_reg[j]   <= '0;
        r_exp_value[j] <= '0;
      end
    end else begin
      if (w_start) begin
        for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
      end else if (w_capture) begin
        r_shadow[wb_write_register] <= wb_write_data;
      end
      if (exp_wr_en && w_cfg) begin
        r_exp_valid[exp_idx] <= exp_valid;
        r_exp_reg[exp_idx]   <= exp_reg;
        r_exp_value[exp_idx] <= exp_value;
      end
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign error_count    = r_error_count;
  assign first_fail_idx = r_first_fail;
  assign cycle_count    = r_cycle_count;

`ifdef MIPS_RUN_TRACE_EN
  localparam int PTR_W = $clog2(TRACE_DEPTH);

  logic [REG_ADDR_WIDTH+DATA_WIDTH-1:0] r_trace_mem [TRACE_DEPTH];
  logic [PTR_W:0] r_wptr, r_rptr;
  logic           r_overflow;
  logic           w_empty, w_full, w_pop, w_push;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) && (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_pop   = trace_rd_en && !w_empty;
  assign w_push  = w_capture && (!w_full || w_pop);

  // Trace pointers and sticky overflow; a full push is only dropped when no pop frees a slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else if (w_start) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (PTR_W+1)'(1);
      if (w_capture && !w_push) r_overflow <= 1'b1;
    end
  end

  // Trace storage
  always_ff @(posedge clk) begin
    if (w_push) r_trace_mem[r_wptr[PTR_W-1:0]] <= {wb_write_register, wb_write_data};
  end

  assign trace_rd_data  = w_empty ? '0 : r_trace_mem[r_rptr[PTR_W-1:0]];
  assign trace_empty    = w_empty;
  assign trace_overflow = r_overflow;
`else
  logic w_unused;
  assign w_unused       = trace_rd_en | (TRACE_DEPTH == 0);
  assign trace_rd_data  = '0;
  assign trace_empty    = 1'b1;
  assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mips_run_checker.sv
// Self-checking bench for mips_run_checker: directed and randomized runs against a behavioural model.
module tb_mips_run_checker;
  localparam int DW = 32, RW = 5, NC = 16, MC = 90, TD = 16, IW = 4, CW = 7;

  logic clk = 1'b0;
  logic reset, wb_reg_write, halt, start, exp_wr_en, exp_valid, trace_rd_en;
  logic [RW-1:0] wb_write_register, exp_reg;
  logic [DW-1:0] wb_write_data, exp_value;
  logic [IW-1:0] exp_idx;
  logic busy, done, pass, timeout, trace_empty, trace_overflow;
  logic [IW:0] error_count;
  logic [IW-1:0] first_fail_idx;
  logic [CW-1:0] cycle_count;
  logic [RW+DW-1:0] trace_rd_data;

  always #5 clk = ~clk;

  mips_run_checker dut (
    .clk(clk), .reset(reset), .wb_reg_write(wb_reg_write), .wb_write_register(wb_write_register),
    .wb_write_data(wb_write_data), .halt(halt), .start(start), .exp_wr_en(exp_wr_en), .exp_idx(exp_idx),
    .exp_valid(exp_valid), .exp_reg(exp_reg), .exp_value(exp_value), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .error_count(error_count), .first_fail_idx(first_fail_idx),
    .cycle_count(cycle_count), .trace_rd_en(trace_rd_en), .trace_rd_data(trace_rd_data),
    .trace_empty(trace_empty), .trace_overflow(trace_overflow)
  );

  int n_cmp = 0, n_fail = 0;

  // reference model: architectural view only
  logic [DW-1:0] m_shadow [32];
  bit            m_valid  [NC];
  logic [RW-1:0] m_reg    [NC];
  logic [DW-1:0] m_val    [NC];
  logic [RW+DW-1:0] m_trace [$];
  bit            m_ovf;
  // per-cycle WB plan for a run, index = RUN cycle number (1-based)
  bit            p_we  [MC+1];
  logic [RW-1:0] p_reg [MC+1];
  logic [DW-1:0] p_dat [MC+1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input int idx, input bit v, input int r, input logic [DW-1:0] val);
    exp_wr_en = 1'b1; exp_idx = IW'(idx); exp_valid = v; exp_reg = RW'(r); exp_value = val;
    tick;
    exp_wr_en = 1'b0;
    m_valid[idx] = v; m_reg[idx] = RW'(r); m_val[idx] = val;
  endtask

  task automatic clear_table;
    for (int i = 0; i < NC; i++) load_entry(i, 1'b0, 0, '0);
  endtask

  task automatic random_table;
    for (int i = 0; i < NC; i++) load_entry(i, 1'($urandom % 2), int'($urandom % 32), DW'($urandom % 4));
  endtask

  task automatic clear_plan;
    for (int k = 0; k <= MC; k++) begin p_we[k] = 1'b0; p_reg[k] = '0; p_dat[k] = '0; end
  endtask

  task automatic random_plan;
    for (int k = 0; k <= MC; k++) begin
      p_we[k] = 1'($urandom % 2); p_reg[k] = RW'($urandom % 32); p_dat[k] = DW'($urandom % 4);
    end
  endtask

  task automatic idle_inputs;
    wb_reg_write = 1'b0; wb_write_register = '0; wb_write_data = '0; halt = 1'b0;
    exp_wr_en = 1'b0; exp_idx = '0; exp_valid = 1'b0; exp_reg = '0; exp_value = '0;
  endtask

  // halt_at outside 1..MC means the run should end on the cycle limit
  task automatic do_run(input string tag, input int halt_at, input bit poke_table);
    int run_len, waited, errs, ff;
    bit to;
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 32; i++) m_shadow[i] = '0;
    m_trace.delete(); m_ovf = 1'b0;
    chk({tag, "_busy_in_run"}, busy, 1);
    to = !(halt_at >= 1 && halt_at <= MC);
    run_len = to ? MC : halt_at;
    for (int k = 1; k <= run_len; k++) begin
      wb_reg_write = p_we[k]; wb_write_register = p_reg[k]; wb_write_data = p_dat[k];
      halt = (k == halt_at);
      if (poke_table) begin
        exp_wr_en = 1'b1; exp_idx = k[IW-1:0]; exp_valid = 1'b1;
        exp_reg = RW'($urandom % 32); exp_value = DW'($urandom | 1);
      end
      if (p_we[k] && p_reg[k] != '0) begin
        m_shadow[p_reg[k]] = p_dat[k];
        if (m_trace.size() < TD) m_trace.push_back({p_reg[k], p_dat[k]});
        else m_ovf = 1'b1;
      end
      tick;
    end
    idle_inputs;
    waited = 0;
    while (!done && waited < 40) begin tick; waited++; end
    chk({tag, "_done_latency"}, waited, NC);
    errs = 0; ff = 0;
    for (int i = 0; i < NC; i++) begin
      if (m_valid[i] && m_shadow[m_reg[i]] !== m_val[i]) begin
        if (errs == 0) ff = i;
        errs++;
      end
    end
    chk({tag, "_error_count"}, error_count, errs);
    chk({tag, "_first_fail_idx"}, first_fail_idx, ff);
    chk({tag, "_pass"}, pass, (errs == 0));
    chk({tag, "_timeout"}, timeout, to);
    chk({tag, "_cycle_count"}, cycle_count, run_len);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; trace_rd_en = 1'b0;
    idle_inputs;
    for (int i = 0; i < NC; i++) begin m_valid[i] = 1'b0; m_reg[i] = '0; m_val[i] = '0; end
    tick; tick;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0); chk("rst_err", error_count, 0); chk("rst_cyc", cycle_count, 0);
    chk("rst_ffi", first_fail_idx, 0); chk("rst_trace_empty", trace_empty, 1);
    chk("rst_trace_ovf", trace_overflow, 0); chk("rst_trace_data", trace_rd_data, 0);
    reset = 1'b0; tick;

    // basic pass, write captured in the halt cycle
    clear_table;
    load_entry(0, 1'b1, 1, 32'd5); load_entry(1, 1'b1, 2, 32'd10); load_entry(2, 1'b1, 13, 32'd0);
    clear_plan;
    p_we[3] = 1'b1; p_reg[3] = 5'd1; p_dat[3] = 32'd5;
    p_we[20] = 1'b1; p_reg[20] = 5'd2; p_dat[20] = 32'd10;
    do_run("t1", 20, 1'b0);

    // timeout with a single mismatch in a random entry
    begin
      int e2;
      e2 = int'($urandom % NC);
      clear_table;
      load_entry(e2, 1'b1, 8, 32'd39);
      clear_plan;
      p_we[MC] = 1'b1; p_reg[MC] = 5'd8; p_dat[MC] = 32'd35;
      do_run("t2", 0, 1'b0);
    end

    // $0 stays zero, table writes in RUN are ignored
    clear_table;
    load_entry(0, 1'b1, 0, 32'd0);
    clear_plan;
    for (int k = 1; k <= 30; k += 3) begin p_we[k] = 1'b1; p_reg[k] = 5'd0; p_dat[k] = 32'd7; end
    do_run("t3", 30, 1'b1);

    // halt on the limit cycle
    random_table; random_plan;
    do_run("t4", MC, 1'b0);

    for (int r = 0; r < 4; r++) begin
      random_table; random_plan;
      do_run($sformatf("rnd%0d", r), int'($urandom % 96), 1'b0);
    end

    // reset in the middle of a run, then a clean rerun with an empty table
    clear_table;
    load_entry(3, 1'b1, 5, 32'd123);
    random_plan;
    start = 1'b1; tick; start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      wb_reg_write = p_we[k]; wb_write_register = p_reg[k]; wb_write_data = p_dat[k]; tick;
    end
    idle_inputs;
    reset = 1'b1; #1;
    chk("t5_busy", busy, 0); chk("t5_done", done, 0); chk("t5_pass", pass, 0);
    chk("t5_cyc", cycle_count, 0); chk("t5_err", error_count, 0); chk("t5_timeout", timeout, 0);
    chk("t5_trace_empty", trace_empty, 1);
    tick; reset = 1'b0; tick;
    for (int i = 0; i < NC; i++) m_valid[i] = 1'b0;
    random_plan;
    do_run("t5b", 15, 1'b0);

`ifdef MIPS_RUN_TRACE_EN
    // 17 writes into a 16-deep trace with no pops
    clear_plan;
    for (int k = 1; k <= 17; k++) begin
      p_we[k] = 1'b1; p_reg[k] = RW'(1 + (k % 31)); p_dat[k] = DW'($urandom);
    end
    do_run("t6", 20, 1'b0);
    chk("t6_overflow", trace_overflow, m_ovf);
    chk("t6_count", m_trace.size(), TD);
    foreach (m_trace[i]) begin
      chk($sformatf("t6_empty_%0d", i), trace_empty, 0);
      chk($sformatf("t6_data_%0d", i), trace_rd_data, m_trace[i]);
      trace_rd_en = 1'b1; tick; trace_rd_en = 1'b0;
    end
    chk("t6_empty_end", trace_empty, 1);
    chk("t6_overflow_sticky", trace_overflow, 1);
`else
    random_plan;
    do_run("t6", 25, 1'b0);
    trace_rd_en = 1'b1; tick; trace_rd_en = 1'b0;
    chk("t6_trace_empty", trace_empty, 1);
    chk("t6_trace_ovf", trace_overflow, 0);
    chk("t6_trace_data", trace_rd_data, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
